// File: rtl/cmp_seq.sv
// cmp_seq: multi-mode branch comparator that resolves one SLICE-bit slice per cycle,
// most-significant slice first, stopping at the first unequal slice.
module cmp_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] RD1,
    input  logic [WIDTH-1:0] RD2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             result,
    output logic             zero,
    output logic             lt
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN = 1'b1;

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a, b;
    logic [2:0]       md;
    logic [SLICE-1:0] flip, xa, xb;
    logic             diff, nz, nl, r, dec;

    // inverting both MSBs of the top slice maps signed order onto unsigned order
    assign flip = {cnt == LAST && md != 3'd3, {(SLICE-1){1'b0}}};
    assign xa   = a[cnt*SLICE +: SLICE] ^ flip;
    assign xb   = b[cnt*SLICE +: SLICE] ^ flip;
    assign diff = xa != xb;
    assign nz   = !diff;
    assign nl   = xa < xb;
    assign dec  = state == RUN && !flush && (diff || cnt == '0);
    assign r    = md == 3'd0 ? nz :
                  md == 3'd1 ? !nz :
                  md == 3'd4 ? nl | nz :
                  md == 3'd5 ? !(nl | nz) :
                  md == 3'd7 ? !nl : nl;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            a      <= '0;
            b      <= '0;
            md     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= 1'b0;
            zero   <= 1'b0;
            lt     <= 1'b0;
        end else begin
            done <= dec;
            if (state == IDLE) begin
                if (start && !flush) begin
                    state <= RUN;
                    busy  <= 1'b1;
                    cnt   <= LAST;
                    a     <= RD1;
                    b     <= mode[2] ? '0 : RD2;
                    md    <= mode;
                end
            end else if (flush || dec) begin
                state <= IDLE;
                busy  <= 1'b0;
                if (dec) begin
                    result <= r;
                    zero   <= nz;
                    lt     <= nl;
                end
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cmp_seq.sv
// tb_cmp_seq: directed and random compares of cmp_seq against an arithmetic
// reference model of the branch conditions and slice-count latency.
module tb_cmp_seq;
    localparam int WIDTH = 32;
    localparam int SLICE = 8;
    localparam int NSLICE = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             reset, start, flush;
    logic [2:0]       mode;
    logic [WIDTH-1:0] RD1, RD2;
    logic             busy, done, result, zero, lt;
    int               checks = 0;
    int               errors = 0;
    logic             exp_r, exp_z, exp_l;

    cmp_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .RD1(RD1), .RD2(RD2),
        .flush(flush), .busy(busy), .done(done), .result(result), .zero(zero), .lt(lt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // m = slices examined: the slice holding the highest differing bit, counted from the top
    function automatic void model(input logic [2:0] md, input logic [31:0] x, input logic [31:0] y,
                                  output logic r, output logic z, output logic l, output int m);
        logic [31:0] yy, d;
        int h;
        yy = md[2] ? 32'd0 : y;
        z = x == yy;
        l = md == 3'd3 ? x < yy : $signed(x) < $signed(yy);
        case (md)
            3'd0: r = z;
            3'd1: r = !z;
            3'd4: r = l | z;
            3'd5: r = !(l | z);
            3'd7: r = !l;
            default: r = l;
        endcase
        d = x ^ yy;
        h = -1;
        for (int i = WIDTH - 1; i >= 0; i--) if (d[i] && h < 0) h = i;
        m = h < 0 ? NSLICE : NSLICE - h / SLICE;
    endfunction

    // called at a negedge; returns at the negedge of the done cycle
    task automatic run(input string tag, input logic [2:0] md, input logic [31:0] x, input logic [31:0] y);
        int m, n, bc;
        bit got;
        model(md, x, y, exp_r, exp_z, exp_l, m);
        start = 1'b1; mode = md; RD1 = x; RD2 = y;
        n = 0; bc = 0; got = 0;
        while (!got && n < NSLICE + 3) begin
            @(negedge clk);
            start = 1'b0; mode = 3'($urandom); RD1 = $urandom; RD2 = $urandom;
            n++;
            if (busy) bc++;
            if (done) got = 1;
        end
        check({tag, ".done_at"}, got ? n : 0, m + 1);
        check({tag, ".busy_cycles"}, bc, m);
        check({tag, ".busy_at_done"}, busy, 0);
        check({tag, ".result"}, result, exp_r);
        check({tag, ".zero"}, zero, exp_z);
        check({tag, ".lt"}, lt, exp_l);
    endtask

    initial begin
        int sel;
        logic [31:0] x, y;
        reset = 1'b0; start = 1'b0; flush = 1'b0; mode = '0; RD1 = '0; RD2 = '0;
        repeat (2) @(negedge clk);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.result", result, 0);
        check("rst.zero", zero, 0);
        check("rst.lt", lt, 0);
        reset = 1'b1;
        @(negedge clk);
        run("eq_equal", 3'd0, 32'h12345678, 32'h12345678);

        start = 1'b1; mode = 3'd0; RD1 = 32'h5; RD2 = 32'h5;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("midrst.busy", busy, 0);
        check("midrst.done", done, 0);
        check("midrst.result", result, 0);
        check("midrst.zero", zero, 0);
        check("midrst.lt", lt, 0);
        @(negedge clk);
        check("midrst.busy_after", busy, 0);

        run("lt_early", 3'd2, 32'h80000000, 32'h00000001);
        run("ltu_early", 3'd3, 32'h80000000, 32'h00000001);
        run("gez_neg", 3'd7, 32'hFFFFFFFF, 32'h5);
        run("lez_zero", 3'd4, 32'h0, 32'hDEADBEEF);
        run("gtz_pos", 3'd5, 32'h00000100, 32'h0);
        run("ne_diff", 3'd1, 32'hA, 32'hB);
        run("ne_same_b2b", 3'd1, 32'hC, 32'hC);
        run("lt_prior", 3'd2, 32'h1, 32'h2);

        start = 1'b1; mode = 3'd0; RD1 = 32'h77; RD2 = 32'h77;
        @(negedge clk);
        RD1 = 32'h1; RD2 = 32'h2; mode = 3'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b1;
        check("flush.busy_before", busy, 1);
        @(negedge clk);
        flush = 1'b0;
        check("flush.busy", busy, 0);
        check("flush.done", done, 0);
        sel = 0;
        repeat (6) begin
            @(negedge clk);
            sel += int'(done) + int'(busy);
        end
        check("flush.no_activity", sel, 0);
        check("flush.result", result, exp_r);
        check("flush.zero", zero, exp_z);
        check("flush.lt", lt, exp_l);

        start = 1'b1; flush = 1'b1; mode = 3'd0;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("startflush.busy", busy, 0);
        @(negedge clk);
        check("startflush.busy2", busy, 0);
        check("startflush.done", done, 0);

        for (int k = 0; k < 60; k++) begin
            x = $urandom;
            sel = $urandom_range(0, 3);
            y = sel == 0 ? x : sel == 1 ? x ^ (32'd1 << $urandom_range(0, 31)) : $urandom;
            run("rand", 3'($urandom_range(0, 7)), x, y);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
